// File: rtl/run_detect_fsm_if.sv
// Serial-line bundle for run_detect_fsm: sample controls in, detector state out.
// hit_count is carried only when RUNDET_HIT_COUNT_EN is defined.
interface run_detect_fsm_if #(
    parameter int LW    = 3,
    parameter int CNT_W = 8
) ();
    logic          en;
    logic          w;
    logic [1:0]    mode;
    logic          retrig;
    logic          z;
    logic          z_val;
    logic [LW-1:0] run_len;
    logic [2:0]    y;
`ifdef RUNDET_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_count;

    modport master (output en, w, mode, retrig,
                    input  z, z_val, run_len, y, hit_count);
    modport slave  (input  en, w, mode, retrig,
                    output z, z_val, run_len, y, hit_count);
`else
    modport master (output en, w, mode, retrig,
                    input  z, z_val, run_len, y);
    modport slave  (input  en, w, mode, retrig,
                    output z, z_val, run_len, y);
`endif
endinterface

// File: rtl/run_detect_fsm.sv
// Run-length detector: z asserts once RUN_LEN consecutive enabled samples of w match.
// Optional saturating hit counter on the bus when RUNDET_HIT_COUNT_EN is defined.
module run_detect_fsm #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic reset,
    run_detect_fsm_if.slave bus
);
    localparam int LW = $clog2(RUN_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(RUN_LEN);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN0 = 3'd1,
        RUN1 = 3'd2,
        HIT0 = 3'd3,
        HIT1 = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic          b;
    logic          match;
    logic          b_en;

    function automatic logic pol_enabled(input logic [1:0] m, input logic pol);
        return (m == 2'b00) || (m == 2'b01 && !pol) || (m == 2'b10 && pol);
    endfunction

    function automatic logic reaches_len(input logic [LW-1:0] l);
        logic [LW:0] s;
        s = {1'b0, l} + 1'b1;
        return s >= (LW+1)'(RUN_LEN);
    endfunction

    function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] l);
        logic [LW:0] s;
        s = {1'b0, l} + 1'b1;
        if (s >= (LW+1)'(RUN_LEN)) return LEN_MAX;
        return s[LW-1:0];
    endfunction

    function automatic logic is_hit(input state_t s);
        return (s == HIT0) || (s == HIT1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        b       = (state_q == RUN1) || (state_q == HIT1);
        match   = (bus.w == b);
        b_en    = pol_enabled(bus.mode, b);
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = bus.w ? RUN1 : RUN0;
                    len_d   = LEN_ONE;
                end
            end
            RUN0, RUN1: begin
                if (bus.en) begin
                    if (!match) begin
                        state_d = b ? RUN0 : RUN1;
                        len_d   = LEN_ONE;
                    end else if (reaches_len(len_q) && b_en) begin
                        state_d = b ? HIT1 : HIT0;
                        len_d   = LEN_MAX;
                    end else begin
                        len_d = sat_inc(len_q);
                    end
                end
            end
            HIT0, HIT1: begin
                // A breaking sample wins; otherwise a disabled polarity drops
                // back to a saturated run even on en=0 edges.
                if (bus.en && !match) begin
                    state_d = b ? RUN0 : RUN1;
                    len_d   = LEN_ONE;
                end else if (!b_en) begin
                    state_d = b ? RUN1 : RUN0;
                    len_d   = LEN_MAX;
                end else if (bus.en && bus.retrig) begin
                    state_d = b ? RUN1 : RUN0;
                    len_d   = LEN_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                len_d   = '0;
            end
        endcase
    end

    assign bus.z       = is_hit(state_q);
    assign bus.z_val   = (state_q == RUN1) || (state_q == HIT1);
    assign bus.run_len = len_q;
    assign bus.y       = state_q;

`ifdef RUNDET_HIT_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             hit_entry;

    assign hit_entry = is_hit(state_d) && !is_hit(state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (hit_entry && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.hit_count = cnt_q;
`endif
endmodule
